saturn_bus_ram: RTL and testbench

Parametrised nibble-wide RAM/ROM peripheral for the Saturn bus, the generalised successor to the fixed-size system RAM. It sits on the shared bus alongside the other memory-mapped devices and is placed in the configuration daisy chain. It tracks its own PC and DP pointers, claims accesses that fall inside its configured window, and supports unconfiguration. Depth and writability are parameters; out-of-depth mirroring is a compile-time option.

---
 rtl/saturn_bus_ram.sv | 126 ++++++++++++
 tb/tb_saturn_bus_ram.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/saturn_bus_ram.sv
// saturn_bus_ram: daisy-chained nibble RAM/ROM with its own PC/DP pointers on the Saturn bus.
// Define SATURN_BUS_RAM_MIRROR_EN to alias windows larger than the storage modulo 2^DEPTH_LOG2.
module saturn_bus_ram #(
  parameter int DEPTH_LOG2 = 16,
  parameter bit READ_ONLY  = 1'b0
) (
  input  logic        strobe_i,
  input  logic        reset_i,
  input  logic [19:0] address_i,
  input  logic [3:0]  command_i,
  input  logic [3:0]  nibble_in_i,
  output logic [3:0]  nibble_out_o,
  output logic        active_o,
  input  logic        daisy_in_i,
  output logic        daisy_out_o,
  output logic        error_o
);
  localparam logic [3:0] CMD_NOP         = 4'h0;
  localparam logic [3:0] CMD_PC_READ     = 4'h1;
  localparam logic [3:0] CMD_DP_READ     = 4'h2;
  localparam logic [3:0] CMD_PC_WRITE    = 4'h3;
  localparam logic [3:0] CMD_DP_WRITE    = 4'h4;
  localparam logic [3:0] CMD_LOAD_PC     = 4'h5;
  localparam logic [3:0] CMD_LOAD_DP     = 4'h6;
  localparam logic [3:0] CMD_CONFIGURE   = 4'h7;
  localparam logic [3:0] CMD_UNCONFIGURE = 4'h8;
  localparam logic [3:0] CMD_RESET       = 4'h9;
  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {UNCFG, SIZED, CONFIGURED} state_e;

  state_e state_q, state_d;
  logic [19:0] base_q, base_d, pc_q, pc_d, dp_q, dp_d;
  logic [20:0] length_q, length_d;
  logic [3:0] out_q, out_d;
  logic err_q, err_d;
  logic [3:0] mem_q [DEPTH];
  logic is_rd, is_wr, use_dp, hit, in_depth;
  logic [19:0] ptr, offset, cfg_off;
  logic [DEPTH_LOG2-1:0] idx;

  always_comb begin
    is_rd = command_i == CMD_PC_READ || command_i == CMD_DP_READ;
    is_wr = command_i == CMD_PC_WRITE || command_i == CMD_DP_WRITE;
    use_dp = command_i == CMD_DP_READ || command_i == CMD_DP_WRITE;
    ptr = use_dp ? dp_q : pc_q;
    offset = ptr - base_q;
    hit = state_q == CONFIGURED && {1'b0, offset} < length_q;
`ifdef SATURN_BUS_RAM_MIRROR_EN
    in_depth = 1'b1;
`else
    in_depth = (offset >> DEPTH_LOG2) == 20'd0;
`endif
    idx = offset[DEPTH_LOG2-1:0];
    active_o = hit && in_depth && (is_rd || (is_wr && !READ_ONLY));
  end

  always_comb begin
    cfg_off = address_i - base_q;
    state_d = state_q;
    base_d = base_q;
    length_d = length_q;
    pc_d = pc_q;
    dp_d = dp_q;
    err_d = err_q;
    out_d = (active_o && is_rd) ? mem_q[idx] : out_q;
    case (command_i)
      CMD_PC_READ, CMD_PC_WRITE: pc_d = pc_q + 20'd1;
      CMD_DP_READ, CMD_DP_WRITE: dp_d = dp_q + 20'd1;
      CMD_LOAD_PC: pc_d = address_i;
      CMD_LOAD_DP: dp_d = address_i;
      CMD_CONFIGURE: begin
        if (daisy_in_i && state_q == UNCFG) begin
          length_d = 21'h100000 - {1'b0, address_i};
          state_d = SIZED;
        end else if (daisy_in_i && state_q == SIZED) begin
          base_d = address_i;
          state_d = CONFIGURED;
        end
      end
      CMD_UNCONFIGURE: begin
        if (state_q == CONFIGURED && {1'b0, cfg_off} < length_q) begin
          state_d = UNCFG;
          base_d = '0;
          length_d = '0;
        end
      end
      CMD_RESET: begin
        state_d = UNCFG;
        base_d = '0;
        length_d = '0;
      end
      CMD_NOP: ;
      default: err_d = 1'b1;
    endcase
  end

  always_ff @(posedge strobe_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= UNCFG;
      base_q <= '0;
      length_q <= '0;
      pc_q <= '0;
      dp_q <= '0;
      out_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q <= base_d;
      length_q <= length_d;
      pc_q <= pc_d;
      dp_q <= dp_d;
      out_q <= out_d;
      err_q <= err_d;
    end
  end

  // Storage is deliberately not reset; a write is dropped while reset is held.
  always_ff @(posedge strobe_i) begin
    if (reset_i && active_o && is_wr) mem_q[idx] <= nibble_in_i;
  end

  assign nibble_out_o = out_q;
  assign daisy_out_o = state_q == CONFIGURED;
  assign error_o = err_q;
endmodule

// File: tb/tb_saturn_bus_ram.sv
// tb_saturn_bus_ram: three configurations of saturn_bus_ram driven together against a behavioural model.
module tb_saturn_bus_ram;
  localparam logic [3:0] C_NOP = 4'h0, C_PC_READ = 4'h1, C_DP_READ = 4'h2, C_PC_WRITE = 4'h3,
                         C_DP_WRITE = 4'h4, C_LOAD_PC = 4'h5, C_LOAD_DP = 4'h6,
                         C_CONFIGURE = 4'h7, C_UNCONFIGURE = 4'h8, C_RESET = 4'h9;
  localparam int MASK = 32'hFFFFF;

  logic clk = 1'b0, rst_n = 1'b0, daisy = 1'b1;
  logic [19:0] addr = '0;
  logic [3:0] cmd = C_NOP, nib = '0;
  logic act [3], dso [3], erro [3];
  logic [3:0] nout [3];

  int checks = 0, errors = 0;
  int st [3], base [3], len [3], pc [3], dp [3];
  bit er [3], ok [3], sa [3];
  logic [3:0] out [3];
  logic [3:0] mem [int];
  int dep [3] = '{16, 16, 8};
  bit ro [3] = '{1'b0, 1'b1, 1'b0};
  bit mirror;

  always #5 clk = ~clk;

  saturn_bus_ram #(.DEPTH_LOG2(16), .READ_ONLY(1'b0)) u0 (
    .strobe_i(clk), .reset_i(rst_n), .address_i(addr), .command_i(cmd), .nibble_in_i(nib),
    .nibble_out_o(nout[0]), .active_o(act[0]), .daisy_in_i(daisy), .daisy_out_o(dso[0]), .error_o(erro[0]));
  saturn_bus_ram #(.DEPTH_LOG2(16), .READ_ONLY(1'b1)) u1 (
    .strobe_i(clk), .reset_i(rst_n), .address_i(addr), .command_i(cmd), .nibble_in_i(nib),
    .nibble_out_o(nout[1]), .active_o(act[1]), .daisy_in_i(daisy), .daisy_out_o(dso[1]), .error_o(erro[1]));
  saturn_bus_ram #(.DEPTH_LOG2(8), .READ_ONLY(1'b0)) u2 (
    .strobe_i(clk), .reset_i(rst_n), .address_i(addr), .command_i(cmd), .nibble_in_i(nib),
    .nibble_out_o(nout[2]), .active_o(act[2]), .daisy_in_i(daisy), .daisy_out_o(dso[2]), .error_o(erro[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic bit is_rd(input logic [3:0] c);
    return c == C_PC_READ || c == C_DP_READ;
  endfunction

  function automatic bit is_wr(input logic [3:0] c);
    return c == C_PC_WRITE || c == C_DP_WRITE;
  endfunction

  function automatic int m_off(input int k);
    int p = (cmd == C_DP_READ || cmd == C_DP_WRITE) ? dp[k] : pc[k];
    return (p - base[k]) & MASK;
  endfunction

  function automatic bit m_active(input int k);
    int off = m_off(k);
    bit hit = st[k] == 2 && off < len[k];
    bit ind = mirror || off < (1 << dep[k]);
    return hit && ind && (is_rd(cmd) || (is_wr(cmd) && !ro[k]));
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      st[k] = 0; base[k] = 0; len[k] = 0; pc[k] = 0; dp[k] = 0;
      er[k] = 0; out[k] = 4'h0; ok[k] = 1;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin
      bit a = m_active(k);
      int key = k * 32'h100000 + (m_off(k) % (1 << dep[k]));
      if (a && is_rd(cmd)) begin
        ok[k] = mem.exists(key);
        if (ok[k]) out[k] = mem[key];
      end
      if (a && is_wr(cmd)) mem[key] = nib;
      case (cmd)
        C_PC_READ, C_PC_WRITE: pc[k] = (pc[k] + 1) & MASK;
        C_DP_READ, C_DP_WRITE: dp[k] = (dp[k] + 1) & MASK;
        C_LOAD_PC: pc[k] = int'(addr);
        C_LOAD_DP: dp[k] = int'(addr);
        C_CONFIGURE: begin
          if (daisy && st[k] == 1) begin base[k] = int'(addr); st[k] = 2; end
          if (daisy && st[k] == 0) begin len[k] = 32'h100000 - int'(addr); st[k] = 1; end
        end
        C_UNCONFIGURE: if (st[k] == 2 && ((int'(addr) - base[k]) & MASK) < len[k]) begin
          st[k] = 0; base[k] = 0; len[k] = 0;
        end
        C_RESET: begin st[k] = 0; base[k] = 0; len[k] = 0; end
        C_NOP: ;
        default: er[k] = 1;
      endcase
    end
  endtask

  task automatic step(input logic [3:0] c, input logic [19:0] a, input logic [3:0] n, input bit d);
    @(negedge clk);
    cmd = c; addr = a; nib = n; daisy = d;
    #1;
    for (int k = 0; k < 3; k++) begin
      sa[k] = act[k];
      check($sformatf("u%0d_active", k), act[k], m_active(k));
      check($sformatf("u%0d_daisy", k), dso[k], st[k] == 2);
      check($sformatf("u%0d_error", k), erro[k], er[k]);
      if (ok[k]) check($sformatf("u%0d_nibble", k), nout[k], out[k]);
    end
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic async_reset();
    @(negedge clk);
    cmd = C_DP_WRITE; nib = 4'hE;
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_u%0d_nibble", k), nout[k], 4'h0);
      check($sformatf("rst_u%0d_daisy", k), dso[k], 1'b0);
      check($sformatf("rst_u%0d_active", k), act[k], 1'b0);
      check($sformatf("rst_u%0d_error", k), erro[k], 1'b0);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1; cmd = C_NOP;
  endtask

  function automatic logic [19:0] rnd_addr();
    case ($urandom_range(0, 3))
      0: return 20'h80000 + 20'($urandom_range(0, 40));
      1: return 20'h8FFF0 + 20'($urandom_range(0, 40));
      2: return 20'hFFFF0 + 20'($urandom_range(0, 40));
      default: return 20'($urandom);
    endcase
  endfunction

  function automatic logic [19:0] rnd_cfg();
    case ($urandom_range(0, 6))
      0: return 20'hF0000;
      1: return 20'hFFF00;
      2: return 20'h80000;
      3: return 20'hFFFF0;
      4: return 20'h00000;
      5: return 20'h8FFF0;
      default: return 20'($urandom);
    endcase
  endfunction

  initial begin
`ifdef SATURN_BUS_RAM_MIRROR_EN
    mirror = 1'b1;
`else
    mirror = 1'b0;
`endif
    model_reset();
    #3;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("init_u%0d_nibble", k), nout[k], 4'h0);
      check($sformatf("init_u%0d_daisy", k), dso[k], 1'b0);
      check($sformatf("init_u%0d_active", k), act[k], 1'b0);
      check($sformatf("init_u%0d_error", k), erro[k], 1'b0);
    end
    @(negedge clk) rst_n = 1'b1;

    step(C_CONFIGURE, 20'hF0000, 0, 1);
    check("cfg_half_daisy", dso[0], 1'b0);
    step(C_CONFIGURE, 20'h80000, 0, 1);
    check("cfg_daisy", dso[0], 1'b1);
    step(C_LOAD_DP, 20'h80010, 0, 1);
    step(C_DP_WRITE, 0, 4'hA, 1);
    check("wr_a_active", sa[0], 1'b1);
    check("rom_wr_active", sa[1], 1'b0);
    step(C_DP_WRITE, 0, 4'hB, 1);
    check("wr_b_active", sa[0], 1'b1);
    step(C_LOAD_DP, 20'h80010, 0, 1);
    step(C_DP_READ, 0, 0, 1);
    check("rd_a_active", sa[0], 1'b1);
    check("rd_a_data", nout[0], 4'hA);
    step(C_DP_READ, 0, 0, 1);
    check("rd_b_data", nout[0], 4'hB);

    step(C_LOAD_PC, 20'h7FFFF, 0, 1);
    step(C_PC_READ, 0, 0, 1);
    check("outside_active", sa[0], 1'b0);
    check("outside_hold", nout[0], 4'hB);
    step(C_PC_READ, 0, 0, 1);
    check("pc_after_outside", sa[0], 1'b1);

    step(C_LOAD_DP, 20'h8FFFE, 0, 1);
    step(C_DP_WRITE, 0, 4'h5, 1);
    check("rom_wr5_active", sa[1], 1'b0);
    step(C_DP_READ, 0, 0, 1);
    check("rom_rd_active", sa[1], 1'b1);
    step(C_DP_READ, 0, 0, 1);
    check("rom_dp_past_end", sa[1], 1'b0);

    step(C_RESET, 0, 0, 1);
    check("busreset_daisy", dso[0], 1'b0);
    step(C_CONFIGURE, 20'hF0000, 0, 0);
    step(C_CONFIGURE, 20'h80000, 0, 0);
    step(C_CONFIGURE, 20'h80000, 0, 1);
    check("gated_cfg_daisy", dso[0], 1'b0);
    step(4'hC, 0, 0, 1);
    check("err_set", erro[0], 1'b1);
    step(C_NOP, 0, 0, 1);
    step(C_PC_READ, 0, 0, 1);
    check("err_sticky", erro[0], 1'b1);
    async_reset();

    step(C_CONFIGURE, 20'hFF000, 0, 1);
    step(C_CONFIGURE, 20'h00000, 0, 1);
    step(C_LOAD_DP, 20'h00003, 0, 1);
    step(C_DP_WRITE, 0, 4'h7, 1);
    step(C_LOAD_DP, 20'h00103, 0, 1);
    step(C_DP_READ, 0, 0, 1);
    check("mirror_active", sa[2], mirror);
    check("mirror_data", nout[2], mirror ? 4'h7 : 4'h0);

    step(C_RESET, 0, 0, 1);
    step(C_CONFIGURE, 20'hF0000, 0, 1);
    step(C_CONFIGURE, 20'h80000, 0, 1);
    step(C_UNCONFIGURE, 20'h80005, 0, 1);
    check("uncfg_daisy", dso[0], 1'b0);
    step(C_CONFIGURE, 20'hFFF00, 0, 1);
    step(C_CONFIGURE, 20'hFFFF0, 0, 1);
    step(C_LOAD_PC, 20'h00000, 0, 1);
    step(C_PC_WRITE, 0, 4'h9, 1);
    step(C_LOAD_PC, 20'hFFFFF, 0, 1);
    step(C_PC_READ, 0, 0, 1);
    check("wrap_top_active", sa[0], 1'b1);
    step(C_PC_READ, 0, 0, 1);
    check("wrap_zero_data", nout[0], 4'h9);

    for (int i = 0; i < 3000; i++) begin
      int r = $urandom_range(0, 99);
      bit d = $urandom_range(0, 7) != 0;
      logic [3:0] n = 4'($urandom);
      if (i % 700 == 699) async_reset();
      if (r < 20) step(C_DP_READ, 0, n, d);
      else if (r < 35) step(C_DP_WRITE, 0, n, d);
      else if (r < 50) step(C_PC_READ, 0, n, d);
      else if (r < 60) step(C_PC_WRITE, 0, n, d);
      else if (r < 68) step(C_LOAD_PC, rnd_addr(), n, d);
      else if (r < 76) step(C_LOAD_DP, rnd_addr(), n, d);
      else if (r < 84) step(C_CONFIGURE, rnd_cfg(), n, d);
      else if (r < 88) step(C_UNCONFIGURE, rnd_addr(), n, d);
      else if (r < 91) step(C_RESET, rnd_addr(), n, d);
      else if (r < 99) step(C_NOP, rnd_addr(), n, d);
      else step(4'($urandom_range(10, 15)), rnd_addr(), n, d);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
